imc_op_sequencer: RTL and testbench
===================================

Name: imc_op_sequencer

Overview:
- Command sequencer directly upstream of the SRAM wordline decoder in the in-memory-computing macro.
- Accepts one operation at a time over a valid/ready command port: plain read, plain write, or dual-row bitline compute with optional write-back.
- Drives the decoder's two read-address/enable pairs and its write address/enable.
- Returns read/compute results on a valid/ready response port, and never asserts any read enable and write enable in the same cycle.

Parameters:
- ADDR_W, 7, row address width (128 rows).
- DATA_W, 32, bitline/word width.
- SA_LATENCY, 2, cycles rows stay activated before sense-amp outputs are valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0 NOP, 1 READ, 2 WRITE, 3 AND, 4 NOR, 5 XOR, 6/7 illegal.
- cmd_src1  in  ADDR_W  first source row; the READ row.
- cmd_src2  in  ADDR_W  second source row (compute only).
- cmd_dst  in  ADDR_W  destination row for WRITE or write-back.
- cmd_wb  in  1  compute result is written back to cmd_dst.
- cmd_wdata  in  DATA_W  WRITE data.
- sa_and  in  DATA_W  sense-amp bitline output (AND of active rows; row data if one row).
- sa_nor  in  DATA_W  sense-amp bitline-bar output (NOR of active rows).
- read_address1  out  ADDR_W  to decoder.
- read_address2  out  ADDR_W  to decoder.
- read_enable1  out  1  to decoder.
- read_enable2  out  1  to decoder.
- write_address  out  ADDR_W  to decoder.
- write_enable  out  1  to decoder.
- write_data  out  DATA_W  to write drivers.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  result.
- rsp_err  out  1  illegal op flag.

Behaviour:
- Reset (async, immediate): state IDLE, all enables 0, all addresses 0, write_data 0, rsp_valid 0, rsp_data 0, rsp_err 0, counter 0.
- Reset mid-operation aborts it with no write performed after reset asserts.
- All outputs come from registers or pure decode of registered state; no combinational path from cmd_* to decoder outputs.
- cmd_ready = 1 only in IDLE.
- A command is accepted on a clk edge with cmd_valid & cmd_ready; its fields are latched then.
- FSM states: IDLE, ACT, WB, WR, RESP.
- IDLE transitions on accept:
  - NOP -> stay IDLE, no response.
  - READ/AND/NOR/XOR -> ACT with counter = SA_LATENCY-1.
  - WRITE -> WR.
  - 6/7 -> RESP with rsp_err=1, rsp_data=0.
- ACT:
  - read_enable1=1, read_address1=src1.
  - read_enable2=1 with read_address2=src2 only for compute ops where src2!=src1; otherwise read_enable2=0, read_address2=0.
  - Counter decrements each cycle.
  - On the edge where counter==0, capture the result:
    - READ, AND -> sa_and.
    - NOR -> sa_nor.
    - XOR -> ~(sa_and | sa_nor), computed at DATA_W width.
  - After capture: next state WB if compute with cmd_wb=1, else RESP.
- WB: for exactly 1 cycle, write_enable=1, write_address=dst, write_data=captured result, read enables 0; then RESP.
- WR: for exactly 1 cycle, write_enable=1, write_address=dst, write_data=cmd_wdata; then RESP with rsp_data=0, rsp_err=0 as completion ack.
- RESP: rsp_valid=1, data and err held stable until rsp_ready is sampled high; then IDLE with rsp_valid=0.
- Latency from accept edge to rsp_valid high:
  - READ/compute without write-back: SA_LATENCY+1 cycles.
  - Compute with write-back: SA_LATENCY+2 cycles.
  - WRITE: 2 cycles.
- Throughput: the next command is accepted at the earliest in the cycle after the RESP handshake.
- dst equal to src1 or src2 is legal; the read completes before the write-back.
- Invariant: write_enable & (read_enable1 | read_enable2) is never 1.

Decomposition:
- Package imc_pkg holds:
  - op_e enum: NOP, READ, WRITE, AND, NOR, XOR.
  - state_e enum.
  - ADDR_W and DATA_W default constants.
  - the compute-result function (op, sa_and, sa_nor) -> DATA_W.
- Single module; no sub-module is warranted. The sense-latency counter stays inline.

Test Plan:
- Reset with cmd_valid high -> cmd_ready=1 and all decoder outputs 0 during reset. WRITE dst=5, wdata=32'hA5A5_0F0F -> write_enable=1, write_address=5 for exactly one cycle, 2 cycles after accept; then rsp_valid with rsp_data=0.
- READ src1=9, sa_and=32'h1234_5678, SA_LATENCY=2 -> read_enable1=1 and read_enable2=0 for 2 cycles; rsp_data=32'h1234_5678 at accept+3.
- XOR src1=3, src2=7, wb=1, dst=3, sa_and=32'h0000_00F0, sa_nor=32'hFFFF_FF00 -> both read enables for 2 cycles; then a write-only cycle to row 3 with data 32'h0000_000F; rsp_data=32'h0000_000F at accept+4.
- AND with src1=src2=12 -> only read_enable1 asserted. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
- Illegal op 7 -> rsp_err=1, rsp_data=0, no read or write enable ever asserted. NOP -> no response, cmd_ready stays 1.
- Assert rst during the WB cycle -> write_enable drops in the same cycle; state returns to IDLE. The one-hot invariant is checked by assertion across all tests.

Source files
------------

// File: rtl/imc_pkg.sv
// Shared types and helpers for the in-memory-compute operation sequencer.
package imc_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_AND   = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_WB   = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    function automatic logic is_compute(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_NOR) || (op == OP_XOR);
    endfunction

    // XOR falls out of the bitline pair: a row pair differs exactly where neither AND nor NOR fires.
    function automatic logic [DEF_DATA_W-1:0] compute_result(
        input op_e                   op,
        input logic [DEF_DATA_W-1:0] sa_and,
        input logic [DEF_DATA_W-1:0] sa_nor
    );
        case (op)
            OP_NOR:  return sa_nor;
            OP_XOR:  return ~(sa_and | sa_nor);
            default: return sa_and;
        endcase
    endfunction

endpackage

// File: rtl/imc_op_sequencer.sv
// Sequences read / write / dual-row bitline compute commands onto the SRAM wordline decoder.
module imc_op_sequencer
    import imc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SA_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_wb,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] sa_and,
    input  logic [DATA_W-1:0] sa_nor,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic              read_enable1,
    output logic              read_enable2,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic              dual_q;
    logic              wb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;
    logic              err_q;
    logic [3:0]        cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_NOP;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            dual_q   <= 1'b0;
            wb_q     <= 1'b0;
            wdata_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        src1_q  <= cmd_src1;
                        src2_q  <= cmd_src2;
                        dst_q   <= cmd_dst;
                        wdata_q <= cmd_wdata;
                        wb_q    <= cmd_wb;
                        // A single activated row already yields its own data on sa_and.
                        dual_q  <= is_compute(cmd_op) && (cmd_src2 != cmd_src1);
                        case (cmd_op)
                            OP_NOP: ;
                            OP_READ, OP_AND, OP_NOR, OP_XOR: begin
                                op_q  <= op_e'(cmd_op);
                                cnt   <= 4'(SA_LATENCY - 1);
                                err_q <= 1'b0;
                                state <= S_ACT;
                            end
                            OP_WRITE: begin
                                op_q     <= OP_WRITE;
                                result_q <= '0;
                                err_q    <= 1'b0;
                                state    <= S_WR;
                            end
                            default: begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                                state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ACT: begin
                    if (cnt == 4'd0) begin
                        result_q <= DATA_W'(compute_result(op_q, DEF_DATA_W'(sa_and),
                                                           DEF_DATA_W'(sa_nor)));
                        state    <= (wb_q && op_q != OP_READ) ? S_WB : S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_WB:    state <= S_RESP;
                S_WR:    state <= S_RESP;
                S_RESP:  if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decoder drive is a pure decode of registered state, so reset clears it immediately.
    assign cmd_ready     = (state == S_IDLE);
    assign read_enable1  = (state == S_ACT);
    assign read_enable2  = (state == S_ACT) && dual_q;
    assign read_address1 = read_enable1 ? src1_q : '0;
    assign read_address2 = read_enable2 ? src2_q : '0;
    assign write_enable  = (state == S_WB) || (state == S_WR);
    assign write_address = write_enable ? dst_q : '0;
    assign write_data    = (state == S_WB) ? result_q :
                           (state == S_WR) ? wdata_q  : '0;
    assign rsp_valid     = (state == S_RESP);
    assign rsp_data      = result_q;
    assign rsp_err       = err_q;

endmodule

// File: tb/tb_imc_op_sequencer.sv
// Directed scoreboard bench for imc_op_sequencer with SA_LATENCY = 2.
module tb_imc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_src1, cmd_src2, cmd_dst;
    logic        cmd_wb;
    logic [31:0] cmd_wdata, sa_and, sa_nor;
    logic [6:0]  read_address1, read_address2, write_address;
    logic        read_enable1, read_enable2, write_enable;
    logic [31:0] write_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;

    imc_op_sequencer #(.ADDR_W(7), .DATA_W(32), .SA_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .cmd_wb(cmd_wb), .cmd_wdata(cmd_wdata),
        .sa_and(sa_and), .sa_nor(sa_nor),
        .read_address1(read_address1), .read_address2(read_address2),
        .read_enable1(read_enable1), .read_enable2(read_enable2),
        .write_address(write_address), .write_enable(write_enable),
        .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic chk_dec(input string tag, input logic e_re1, input logic [6:0] e_ra1,
                           input logic e_re2, input logic [6:0] e_ra2, input logic e_we,
                           input logic [6:0] e_wa, input logic [31:0] e_wd);
        chk({tag, ".re1"}, 32'(read_enable1), 32'(e_re1));
        chk({tag, ".ra1"}, 32'(read_address1), 32'(e_ra1));
        chk({tag, ".re2"}, 32'(read_enable2), 32'(e_re2));
        chk({tag, ".ra2"}, 32'(read_address2), 32'(e_ra2));
        chk({tag, ".we"}, 32'(write_enable), 32'(e_we));
        chk({tag, ".wa"}, 32'(write_address), 32'(e_wa));
        chk({tag, ".wd"}, 32'(write_data), e_wd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a command in the accept cycle; returns one cycle after the accept edge.
    task automatic send(input logic [2:0] op, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] d, input logic wb, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_dst   = d;
        cmd_wb    = wb;
        cmd_wdata = wd;
        @(negedge clk);
        chk("accept.cmd_ready", 32'(cmd_ready), 32'd1);
        next_cycle();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp.unexpected: got data=%h err=%0d expected no response",
                         rsp_data, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp.data", rsp_data, e.data);
                chk("rsp.err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Read and write enables must never overlap.
    always @(negedge clk) begin
        if (write_enable) begin
            total++;
            if (read_enable1 || read_enable2) begin
                bad++;
                $display("FAIL onehot: got re1=%0d re2=%0d we=1 expected no read enable",
                         read_enable1, read_enable2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_src1 = 7'd1; cmd_src2 = 7'd2;
        cmd_dst = 7'd5; cmd_wb = 1'b1; cmd_wdata = 32'hFFFF_FFFF;
        sa_and = 32'h0; sa_nor = 32'h0;

        // Reset held with a command offered
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_data", rsp_data, 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk_dec("rst", 0, 0, 0, 0, 0, 0, 32'd0);
        cmd_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // WRITE dst=5
        exp_q.push_back('{data: 32'h0, err: 1'b0});
        send(3'd2, 7'd0, 7'd0, 7'd5, 1'b0, 32'hA5A5_0F0F);
        @(negedge clk);
        chk_dec("wr.c1", 0, 0, 0, 0, 1, 7'd5, 32'hA5A5_0F0F);
        chk("wr.c1.rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk_dec("wr.c2", 0, 0, 0, 0, 0, 0, 32'd0);
        chk("wr.c2.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr.c2.cmd_ready", 32'(cmd_ready), 32'd0);
        next_cycle();
        chk("wr.after.cmd_ready", 32'(cmd_ready), 32'd1);

        // READ src1=9
        sa_and = 32'h1234_5678; sa_nor = 32'hEDCB_A987;
        exp_q.push_back('{data: 32'h1234_5678, err: 1'b0});
        send(3'd1, 7'd9, 7'd4, 7'd0, 1'b1, 32'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk_dec("rd.act", 1, 7'd9, 0, 0, 0, 0, 32'd0);
            chk("rd.act.rsp_valid", 32'(rsp_valid), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("rd.c3.rsp_valid", 32'(rsp_valid), 32'd1);
        chk_dec("rd.c3", 0, 0, 0, 0, 0, 0, 32'd0);
        next_cycle();

        // XOR src1=3 src2=7 with write-back to row 3
        sa_and = 32'h0000_00F0; sa_nor = 32'hFFFF_FF00;
        exp_q.push_back('{data: 32'h0000_000F, err: 1'b0});
        send(3'd5, 7'd3, 7'd7, 7'd3, 1'b1, 32'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk_dec("xor.act", 1, 7'd3, 1, 7'd7, 0, 0, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk_dec("xor.wb", 0, 0, 0, 0, 1, 7'd3, 32'h0000_000F);
        chk("xor.wb.rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("xor.c4.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("xor.c4.we", 32'(write_enable), 32'd0);
        next_cycle();

        // AND with identical rows, response back-pressured for 5 cycles
        sa_and = 32'hCAFE_BABE; sa_nor = 32'h0101_0101;
        rsp_ready = 1'b0;
        exp_q.push_back('{data: 32'hCAFE_BABE, err: 1'b0});
        send(3'd3, 7'd12, 7'd12, 7'd0, 1'b0, 32'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk_dec("and.act", 1, 7'd12, 0, 0, 0, 0, 32'd0);
            next_cycle();
        end
        sa_and = 32'h0; sa_nor = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("and.hold.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("and.hold.rsp_data", rsp_data, 32'hCAFE_BABE);
            chk("and.hold.cmd_ready", 32'(cmd_ready), 32'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        next_cycle();
        chk("and.after.cmd_ready", 32'(cmd_ready), 32'd1);

        // Illegal op 7
        exp_q.push_back('{data: 32'h0, err: 1'b1});
        send(3'd7, 7'd1, 7'd2, 7'd3, 1'b1, 32'h1111_1111);
        @(negedge clk);
        chk("ill.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ill.rsp_err", 32'(rsp_err), 32'd1);
        chk_dec("ill", 0, 0, 0, 0, 0, 0, 32'd0);
        next_cycle();

        // NOP produces nothing
        send(3'd0, 7'd1, 7'd2, 7'd3, 1'b1, 32'h2222_2222);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("nop.cmd_ready", 32'(cmd_ready), 32'd1);
            chk("nop.rsp_valid", 32'(rsp_valid), 32'd0);
            chk_dec("nop", 0, 0, 0, 0, 0, 0, 32'd0);
            next_cycle();
        end

        // Reset asserted during the write-back cycle
        sa_and = 32'h0F0F_0F0F; sa_nor = 32'h3030_3030;
        send(3'd4, 7'd20, 7'd21, 7'd20, 1'b1, 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rstwb.we_before", 32'(write_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwb.we_after", 32'(write_enable), 32'd0);
        chk("rstwb.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstwb.rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_dec("rstwb.idle", 0, 0, 0, 0, 0, 0, 32'd0);
            chk("rstwb.idle.rsp_valid", 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Recovery READ after reset
        sa_and = 32'h5555_AAAA; sa_nor = 32'h0;
        exp_q.push_back('{data: 32'h5555_AAAA, err: 1'b0});
        send(3'd1, 7'd127, 7'd0, 7'd0, 1'b0, 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rec.rsp_valid", 32'(rsp_valid), 32'd1);
        next_cycle();
        repeat (2) next_cycle();

        chk("sb.empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
